// File: rtl/mm_result_collector_pkg.sv
// Shared matrix-multiplier definitions: default dimension, data width and
// the index/occupancy widths derived from the log2 dimension.
package mm_result_collector_pkg;

    localparam int MM_M   = 5;
    localparam int MM_N   = 2 ** MM_M;
    localparam int DATA_W = 8;
    localparam int IDX_W  = MM_M;
    localparam int PTR_W  = 2 * MM_M;
    localparam int CNT_W  = 2 * MM_M + 1;

    typedef logic [DATA_W-1:0] res_byte_t;

    // Width helpers so a block overriding M derives the same geometry.
    function automatic int ptr_width(input int m);
        return 2 * m;
    endfunction

    function automatic int cnt_width(input int m);
        return 2 * m + 1;
    endfunction

endpackage

// File: rtl/mm_res_fifo.sv
// In-order result FIFO, one matrix frame deep, with asynchronous read of the
// head entry and pointers that wrap naturally at the frame size.
module mm_res_fifo
    import mm_result_collector_pkg::*;
#(
    parameter int M = MM_M
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en_i,
    input  logic [DATA_W-1:0]         wr_data_i,
    input  logic                      rd_en_i,
    output logic [DATA_W-1:0]         rd_data_o,
    output logic [ptr_width(M)-1:0]   rd_ptr_o,
    output logic                      full_o,
    output logic                      empty_o
);

    localparam int PW    = ptr_width(M);
    localparam int CW    = cnt_width(M);
    localparam int DEPTH = 2 ** PW;

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic wr_ok;
    logic rd_ok;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);

    // A full buffer still accepts a write when the head leaves in the same cycle.
    assign rd_ok = rd_en_i & ~empty_o;
    assign wr_ok = wr_en_i & (~full_o | rd_ok) & ~reset;

    // NOTE: every always_comb output gets its default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign rd_ptr_o  = rd_ptr_q;

endmodule

// File: rtl/mm_result_collector.sv
// Collects matrix-multiplier result bytes into a frame buffer and streams
// them out tagged with row/column, flagging frame ends and dropped bytes.
module mm_result_collector
    import mm_result_collector_pkg::*;
#(
    parameter int M = MM_M,
    parameter int N = 2 ** M
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] res_in,
    input  logic              res_en,
    output logic [DATA_W-1:0] m_data,
    output logic [M-1:0]      m_row,
    output logic [M-1:0]      m_col,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              frame_done,
    output logic              overflow
);

    localparam int PW = ptr_width(M);
    localparam logic [PW-1:0] LAST_IDX = PW'(N * N - 1);

    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          handshake;

    logic frame_done_q, frame_done_d;
    logic overflow_q, overflow_d;

    mm_res_fifo #(
        .M (M)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (res_en),
        .wr_data_i (res_in),
        .rd_en_i   (m_ready),
        .rd_data_o (m_data),
        .rd_ptr_o  (rd_ptr),
        .full_o    (full),
        .empty_o   (empty)
    );

    assign m_valid   = ~empty;
    assign handshake = m_valid & m_ready;

    // The read pointer is the element's position within its frame.
    assign m_row  = rd_ptr[PW-1:M];
    assign m_col  = rd_ptr[M-1:0];
    assign m_last = (rd_ptr == LAST_IDX);

    always_comb begin
        frame_done_d = handshake & m_last;
        overflow_d   = overflow_q | (res_en & full & ~handshake);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_mm_result_collector.sv
// Self-checking bench for mm_result_collector at M=2 (4x4, 16-byte frames),
// driven against a queue-based reference model of the collector.
module tb_mm_result_collector;

    localparam int M     = 2;
    localparam int N     = 4;
    localparam int FRAME = N * N;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] res_in;
    logic       res_en;
    logic [7:0] m_data;
    logic [1:0] m_row;
    logic [1:0] m_col;
    logic       m_last;
    logic       m_valid;
    logic       m_ready;
    logic       frame_done;
    logic       overflow;

    always #5 clk = ~clk;

    mm_result_collector #(
        .M (M),
        .N (N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .res_in     (res_in),
        .res_en     (res_en),
        .m_data     (m_data),
        .m_row      (m_row),
        .m_col      (m_col),
        .m_last     (m_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: contents in order, elements read since reset, flags.
    logic [7:0] mq[$];
    int         rd_cnt = 0;
    bit         ov_m   = 1'b0;
    bit         fd_m   = 1'b0;

    // Values sampled at the last step, and handshaken output captures.
    logic       s_valid, s_last, s_fd, s_ov;
    logic [7:0] s_data;
    logic [1:0] s_row, s_col;
    logic [7:0] out_data[$];
    logic [3:0] out_tag[$];
    int         fd_seen = 0;
    bit         stab_en = 1'b0;
    bit         stall_prev = 1'b0;
    logic [7:0] p_data;
    logic [1:0] p_row, p_col;
    logic       p_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, sample and compare mid-cycle, advance model.
    task automatic step(input logic rst, input logic en, input logic [7:0] d,
                        input logic rdy, input bit chk);
        bit hs;
        bit full;
        int idx;
        reset  = rst;
        res_en = en;
        res_in = d;
        m_ready = rdy;
        @(negedge clk);
        s_valid = m_valid; s_data = m_data; s_row = m_row; s_col = m_col;
        s_last = m_last; s_fd = frame_done; s_ov = overflow;
        if (chk) begin
            check("m_valid", 32'(m_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                idx = rd_cnt % FRAME;
                check("m_data", 32'(m_data), 32'(mq[0]));
                check("m_row",  32'(m_row),  32'(idx / N));
                check("m_col",  32'(m_col),  32'(idx % N));
                check("m_last", 32'(m_last), 32'(idx == FRAME - 1));
            end
            check("frame_done", 32'(frame_done), 32'(fd_m));
            check("overflow",   32'(overflow),   32'(ov_m));
            if (stab_en && stall_prev) begin
                check("stall_data", 32'(m_data), 32'(p_data));
                check("stall_tag",  32'({m_row, m_col, m_last}), 32'({p_row, p_col, p_last}));
            end
            if (m_valid === 1'b1 && rdy) begin
                out_data.push_back(m_data);
                out_tag.push_back({m_row, m_col});
            end
        end
        if (frame_done === 1'b1) fd_seen++;
        stall_prev = !rst && (m_valid === 1'b1) && !rdy;
        p_data = m_data; p_row = m_row; p_col = m_col; p_last = m_last;

        if (rst) begin
            mq.delete();
            rd_cnt = 0;
            ov_m   = 1'b0;
            fd_m   = 1'b0;
        end else begin
            full = (mq.size() == FRAME);
            hs   = (mq.size() != 0) && rdy;
            fd_m = hs && (rd_cnt % FRAME == FRAME - 1);
            if (hs) begin
                void'(mq.pop_front());
                rd_cnt++;
            end
            if (en) begin
                if (!full || hs) mq.push_back(d);
                else ov_m = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        out_data.delete();
        out_tag.delete();
        fd_seen = 0;
    endtask

    typedef struct {
        logic       en;
        logic [7:0] d;
        logic       rdy;
        logic       v;
        logic [7:0] data;
        logic [1:0] row;
        logic [1:0] col;
        logic       last;
        logic       fd;
    } vec_t;

    vec_t tbl[19];

    initial begin
        int cyc;
        int n_wr;
        reset = 1'b1; res_en = 1'b0; res_in = 8'h00; m_ready = 1'b0;

        // Reset state.
        do_reset();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("rst_valid", 32'(s_valid), 32'd0);
        check("rst_fd",    32'(s_fd),    32'd0);
        check("rst_ov",    32'(s_ov),    32'd0);
        check("rst_tag",   32'({s_row, s_col}), 32'd0);

        // One full frame streamed straight through, as a vector table.
        for (int i = 0; i < 19; i++) begin
            tbl[i].en   = (i < FRAME);
            tbl[i].d    = 8'(i);
            tbl[i].rdy  = 1'b1;
            tbl[i].v    = (i >= 1 && i <= FRAME);
            tbl[i].data = 8'(i - 1);
            tbl[i].row  = 2'((i - 1) / N);
            tbl[i].col  = 2'((i - 1) % N);
            tbl[i].last = (i == FRAME);
            tbl[i].fd   = (i == FRAME + 1);
        end
        do_reset();
        for (int i = 0; i < 19; i++) begin
            step(1'b0, tbl[i].en, tbl[i].d, tbl[i].rdy, 1'b1);
            check("vec_valid", 32'(s_valid), 32'(tbl[i].v));
            check("vec_fd",    32'(s_fd),    32'(tbl[i].fd));
            if (tbl[i].v) begin
                check("vec_data", 32'(s_data), 32'(tbl[i].data));
                check("vec_tag",  32'({s_row, s_col, s_last}),
                      32'({tbl[i].row, tbl[i].col, tbl[i].last}));
            end
        end
        check("frame1_fd_pulses", 32'(fd_seen), 32'd1);
        check("frame1_count", 32'(out_data.size()), 32'd16);

        // Overflow: 17 writes into a stalled 16-entry buffer, then drain.
        do_reset();
        for (int i = 0; i < FRAME; i++) step(1'b0, 1'b1, 8'(8'hA0 + i), 1'b0, 1'b1);
        step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_set", 32'(s_ov), 32'd1);
        for (int i = 0; i < FRAME + 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        check("ovf_drain_count", 32'(out_data.size()), 32'd16);
        for (int i = 0; i < out_data.size(); i++)
            check("ovf_drain_data", 32'(out_data[i]), 32'(8'hA0 + i));
        check("ovf_sticky", 32'(s_ov), 32'd1);

        // Full buffer with simultaneous write and read.
        do_reset();
        for (int i = 0; i < FRAME; i++) step(1'b0, 1'b1, 8'(i), 1'b0, 1'b1);
        step(1'b0, 1'b1, 8'h55, 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("full_rw_no_ovf", 32'(s_ov), 32'd0);
        for (int i = 0; i < FRAME + 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        check("full_rw_count", 32'(out_data.size()), 32'd17);
        if (out_data.size() == 17) begin
            check("full_rw_data", 32'(out_data[16]), 32'h55);
            check("full_rw_tag",  32'(out_tag[16]),  32'd0);
        end

        // Two back-to-back frames with random stalls.
        do_reset();
        stab_en = 1'b1;
        n_wr = 0;
        cyc  = 0;
        while ((n_wr < 2 * FRAME || mq.size() != 0) && cyc < 2000) begin
            logic en;
            en = (n_wr < 2 * FRAME) && (mq.size() < FRAME) && ($urandom_range(3) != 0);
            step(1'b0, en, 8'($urandom), logic'($urandom_range(2) != 0), 1'b1);
            if (en) n_wr++;
            cyc++;
        end
        check("rand_timeout", 32'(cyc < 2000), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("rand_fd_pulses", 32'(fd_seen), 32'd2);
        check("rand_count", 32'(out_data.size()), 32'(2 * FRAME));
        if (out_data.size() > FRAME) check("rand_f2_tag", 32'(out_tag[FRAME]), 32'd0);
        stab_en = 1'b0;

        // Reset mid-frame after 7 writes and 3 reads.
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'(8'h30 + i), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("midrst_valid", 32'(s_valid), 32'd0);
        check("midrst_ov",    32'(s_ov),    32'd0);
        step(1'b0, 1'b1, 8'h11, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        check("midrst_data", 32'(s_data), 32'h11);
        check("midrst_tag",  32'({s_valid, s_row, s_col}), 32'h10);

        // Unconstrained traffic, including overflow while streaming.
        do_reset();
        for (int i = 0; i < 400; i++)
            step(1'b0, logic'($urandom_range(1)), 8'($urandom), logic'($urandom_range(3) == 0), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mm_result_collector.md
MM_RESULT_COLLECTOR -- requirements
Module: mm_result_collector

Interface
REQ-001 Parameter M, default 5, log2 of matrix dimension.
REQ-002 Parameter N, default 2**M, matrix dimension; result frame = N*N bytes.
REQ-003 Reset is reset, synchronous, active-high; clock is clk.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 res_in  input  8  result byte from the upstream matrix multiplier.
REQ-007 res_en  input  1  res_in valid this cycle; no backpressure is possible upstream.
REQ-008 m_data  output  8  head-of-buffer result byte.
REQ-009 m_row  output  M  row index of m_data within its frame.
REQ-010 m_col  output  M  column index of m_data within its frame.
REQ-011 m_last  output  1  m_data is element N*N-1 of its frame.
REQ-012 m_valid  output  1  m_data/m_row/m_col/m_last are valid.
REQ-013 m_ready  input  1  downstream accepts the head element.
REQ-014 frame_done  output  1  one-cycle pulse after the last element of a frame is accepted.
REQ-015 overflow  output  1  sticky; a result byte was dropped.

Function
REQ-016 The block SHALL buffer results in an in-order FIFO of depth N*N, 8 bits wide.
REQ-017 A write SHALL occur on each cycle with res_en=1 and the buffer not full, or full with a read in the same cycle.
REQ-018 A read (handshake) SHALL occur on each cycle with m_valid=1 and m_ready=1.
REQ-019 Pointers wr_ptr and rd_ptr SHALL be 2M bits wide and wrap modulo N*N; occupancy count SHALL be 2M+1 bits wide.
REQ-020 m_valid SHALL equal (count != 0); a byte written at edge t SHALL be visible on m_data after edge t (one-cycle latency).
REQ-021 m_data SHALL be the entry at rd_ptr; m_row = rd_ptr[2M-1:M]; m_col = rd_ptr[M-1:0]; m_last = (rd_ptr == N*N-1).
REQ-022 Outputs SHALL hold stable while m_valid=1 and m_ready=0.
REQ-023 A simultaneous write and read SHALL leave count unchanged and advance both pointers.
REQ-024 res_en=1 while full with no read SHALL drop the byte, leave wr_ptr unchanged, and set overflow=1 until reset.
REQ-025 m_ready with m_valid=0 SHALL have no effect.
REQ-026 frame_done SHALL be 1 for exactly the cycle following a handshake with m_last=1, and 0 otherwise.
REQ-027 Pointer wrap from N*N-1 to 0 SHALL start the next frame at row 0, col 0 with no idle cycle.

Reset
REQ-028 On reset, wr_ptr, rd_ptr, and count SHALL be 0; m_valid, frame_done, and overflow SHALL be 0; m_row and m_col SHALL be 0.
REQ-029 Buffer storage SHALL NOT require reset; a reset mid-frame SHALL discard all buffered data, and writes in the reset cycle SHALL be ignored.

Structure
REQ-030 The shared matrix package SHALL hold M, N, the data width of 8, and the derived index widths.
REQ-031 The FIFO SHALL be a sub-module mm_res_fifo; tagging, frame_done, and overflow logic SHALL stay in the top module.

Verification (M=2, N=4, 16-entry frame)
REQ-032 Reset, then 16 cycles of res_en with bytes 0x00..0x0F and m_ready=1 -> 16 handshakes in order; first (row 0, col 0, data 0x00) one cycle after the first write; last (row 3, col 3, data 0x0F, m_last=1); frame_done pulses once.
REQ-033 m_ready=0, 16 writes 0xA0..0xAF, then a 17th write 0xFF -> overflow=1; after m_ready=1, exactly 0xA0..0xAF drain and 0xFF never appears.
REQ-034 Full buffer, then res_en=1 with 0x55 and m_ready=1 in the same cycle -> no overflow; count stays 16; 0x55 later emerges tagged row 0, col 0 of frame 2.
REQ-035 Random m_ready stall pattern over two back-to-back frames -> data order preserved; outputs stable during stalls; two frame_done pulses; tags restart at row 0, col 0.
REQ-036 Reset asserted after 7 writes and 3 reads -> next cycle m_valid=0 and overflow=0; a new write of 0x11 emerges tagged row 0, col 0.
